// File: rtl/mmc3_scanline_irq.sv
// MMC3 scanline IRQ: filtered PPU A12 rise counter with CPU-controlled latch.
// Define MMC3_NEC_IRQ_EN for the NEC zero-test behaviour (default: Sharp).
module mmc3_scanline_irq #(
  parameter int A12_LOW_MIN = 3,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 m2,
  input  logic                 rst_n,
  input  logic                 ppu_a12,
  input  logic                 reg_we,
  input  logic [1:0]           reg_sel,
  input  logic [CNT_WIDTH-1:0] reg_data,
  output logic                 irq_n,
  output logic [CNT_WIDTH-1:0] counter_out
);

  localparam logic [2:0] LOW_MIN = 3'(A12_LOW_MIN);

  logic                 a12_s1, a12_s2, a12_s3;
  logic [2:0]           low_cnt;
  logic [CNT_WIDTH-1:0] latch, counter, cnt_next;
  logic                 reload_pending, irq_enable, irq_pending;
  logic                 ce, do_reload, fire;
  logic                 wr_latch, wr_reload, wr_ack, wr_en;

  assign wr_latch  = reg_we && (reg_sel == 2'd0);
  assign wr_reload = reg_we && (reg_sel == 2'd1);
  assign wr_ack    = reg_we && (reg_sel == 2'd2);
  assign wr_en     = reg_we && (reg_sel == 2'd3);

  assign ce = a12_s2 & ~a12_s3 & (low_cnt >= LOW_MIN);

  always_comb begin
    do_reload = (counter == '0) || reload_pending;
    cnt_next  = do_reload ? latch : counter - CNT_WIDTH'(1);
`ifdef MMC3_NEC_IRQ_EN
    // NEC parts only fire when the counter actually transitions to zero
    fire = ce && (cnt_next == '0) && irq_enable &&
           ((counter != '0) || reload_pending);
`else
    fire = ce && (cnt_next == '0) && irq_enable;
`endif
  end

  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      a12_s1 <= 1'b0;
      a12_s2 <= 1'b0;
      a12_s3 <= 1'b0;
      low_cnt <= 3'd0;
    end else begin
      a12_s1 <= ppu_a12;
      a12_s2 <= a12_s1;
      a12_s3 <= a12_s2;
      if (a12_s2)
        low_cnt <= 3'd0;
      else if (low_cnt != 3'd7)
        low_cnt <= low_cnt + 3'd1;
    end
  end

  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      latch          <= '0;
      counter        <= '0;
      reload_pending <= 1'b0;
      irq_enable     <= 1'b0;
      irq_pending    <= 1'b0;
    end else begin
      if (wr_latch)
        latch <= reg_data;
      // CPU reload write wins over a coincident clock event
      if (wr_reload) begin
        counter        <= '0;
        reload_pending <= 1'b1;
      end else if (ce) begin
        counter        <= cnt_next;
        reload_pending <= 1'b0;
      end
      if (wr_ack)
        irq_enable <= 1'b0;
      else if (wr_en)
        irq_enable <= 1'b1;
      if (wr_ack)
        irq_pending <= 1'b0;
      else if (fire)
        irq_pending <= 1'b1;
    end
  end

  assign irq_n       = ~irq_pending;
  assign counter_out = counter;

endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// Directed bench for mmc3_scanline_irq.
// Expectations follow the MMC3_NEC_IRQ_EN setting of the build.
module tb_mmc3_scanline_irq;

  logic       m2 = 1'b0;
  logic       rst_n;
  logic       ppu_a12;
  logic       reg_we;
  logic [1:0] reg_sel;
  logic [7:0] reg_data;
  logic       irq_n;
  logic [7:0] counter_out;

  int checks = 0;
  int errors = 0;

  mmc3_scanline_irq #(.A12_LOW_MIN(3), .CNT_WIDTH(8)) dut (
    .m2(m2),
    .rst_n(rst_n),
    .ppu_a12(ppu_a12),
    .reg_we(reg_we),
    .reg_sel(reg_sel),
    .reg_data(reg_data),
    .irq_n(irq_n),
    .counter_out(counter_out)
  );

  always #5 m2 = ~m2;

  task automatic wr(input logic [1:0] sel, input logic [7:0] d);
    reg_we = 1'b1;
    reg_sel = sel;
    reg_data = d;
    @(negedge m2);
    reg_we = 1'b0;
  endtask

  // Low 8 cycles, high 4; optional write lands on the edge that applies ce.
  task automatic pulse(input logic w, input logic [1:0] sel,
                       input logic [7:0] d,
                       output logic irq2, output logic irq3);
    ppu_a12 = 1'b0;
    repeat (8) @(negedge m2);
    ppu_a12 = 1'b1;
    @(negedge m2);
    @(negedge m2);
    irq2 = irq_n;
    if (w) begin
      reg_we = 1'b1;
      reg_sel = sel;
      reg_data = d;
    end
    @(negedge m2);
    reg_we = 1'b0;
    irq3 = irq_n;
    @(negedge m2);
  endtask

  task automatic test_reset_count;
    logic i2, i3;
    logic [7:0] exp;
    rst_n = 1'b0;
    ppu_a12 = 1'b0;
    reg_we = 1'b0;
    reg_sel = 2'd0;
    reg_data = 8'd0;
    repeat (3) @(negedge m2);
    checks++;
    if (irq_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_irq_n got %b want 1", irq_n);
    end
    checks++;
    if (counter_out !== 8'd0) begin
      errors++;
      $display("FAIL reset_counter got %0d want 0", counter_out);
    end
    rst_n = 1'b1;
    @(negedge m2);
    wr(2'd0, 8'd3);
    wr(2'd1, 8'd0);
    wr(2'd3, 8'd0);
    for (int i = 0; i < 4; i++) begin
      pulse(1'b0, 2'd0, 8'd0, i2, i3);
      exp = 8'(3 - i);
      checks++;
      if (counter_out !== exp) begin
        errors++;
        $display("FAIL count_seq[%0d] got %0d want %0d", i, counter_out, exp);
      end
    end
    checks++;
    if (i2 !== 1'b1 || i3 !== 1'b0) begin
      errors++;
      $display("FAIL irq_timing got edge2=%b edge3=%b want 1 0", i2, i3);
    end
  endtask

  task automatic test_ack_reload;
    logic i2, i3;
    logic [7:0] exp;
    wr(2'd2, 8'd0);
    checks++;
    if (irq_n !== 1'b1) begin
      errors++;
      $display("FAIL ack_irq_n got %b want 1", irq_n);
    end
    for (int i = 0; i < 4; i++) begin
      pulse(1'b0, 2'd0, 8'd0, i2, i3);
      exp = 8'(3 - i);
      checks++;
      if (counter_out !== exp) begin
        errors++;
        $display("FAIL ack_seq[%0d] got %0d want %0d", i, counter_out, exp);
      end
    end
    checks++;
    if (irq_n !== 1'b1) begin
      errors++;
      $display("FAIL disabled_irq got %b want 1", irq_n);
    end
  endtask

  task automatic test_low_filter;
    wr(2'd3, 8'd0);
    for (int i = 0; i < 10; i++) begin
      ppu_a12 = 1'b0;
      repeat (2) @(negedge m2);
      ppu_a12 = 1'b1;
      repeat (2) @(negedge m2);
    end
    repeat (4) @(negedge m2);
    checks++;
    if (counter_out !== 8'd0) begin
      errors++;
      $display("FAIL filter_counter got %0d want 0", counter_out);
    end
    checks++;
    if (irq_n !== 1'b1) begin
      errors++;
      $display("FAIL filter_irq got %b want 1", irq_n);
    end
  endtask

  task automatic test_latch_zero;
    logic i2, i3;
    logic want;
`ifdef MMC3_NEC_IRQ_EN
    want = 1'b1;
`else
    want = 1'b0;
`endif
    wr(2'd2, 8'd0);
    wr(2'd0, 8'd0);
    wr(2'd1, 8'd0);
    wr(2'd3, 8'd0);
    pulse(1'b0, 2'd0, 8'd0, i2, i3);
    checks++;
    if (irq_n !== 1'b0) begin
      errors++;
      $display("FAIL latch0_p1 got %b want 0", irq_n);
    end
    for (int i = 2; i <= 3; i++) begin
      wr(2'd2, 8'd0);
      checks++;
      if (irq_n !== 1'b1) begin
        errors++;
        $display("FAIL latch0_ack%0d got %b want 1", i, irq_n);
      end
      wr(2'd3, 8'd0);
      pulse(1'b0, 2'd0, 8'd0, i2, i3);
      checks++;
      if (irq_n !== want) begin
        errors++;
        $display("FAIL latch0_p%0d got %b want %b", i, irq_n, want);
      end
    end
  endtask

  task automatic test_collision;
    logic i2, i3;
    wr(2'd2, 8'd0);
    wr(2'd0, 8'd5);
    wr(2'd1, 8'd0);
    pulse(1'b0, 2'd0, 8'd0, i2, i3);
    checks++;
    if (counter_out !== 8'd5) begin
      errors++;
      $display("FAIL coll_setup got %0d want 5", counter_out);
    end
    wr(2'd0, 8'd7);
    pulse(1'b1, 2'd1, 8'd0, i2, i3);
    checks++;
    if (counter_out !== 8'd0) begin
      errors++;
      $display("FAIL coll_sel1 got %0d want 0", counter_out);
    end
    pulse(1'b0, 2'd0, 8'd0, i2, i3);
    checks++;
    if (counter_out !== 8'd7) begin
      errors++;
      $display("FAIL coll_reload got %0d want 7", counter_out);
    end
    wr(2'd0, 8'd1);
    wr(2'd1, 8'd0);
    wr(2'd3, 8'd0);
    pulse(1'b0, 2'd0, 8'd0, i2, i3);
    checks++;
    if (counter_out !== 8'd1) begin
      errors++;
      $display("FAIL coll2_setup got %0d want 1", counter_out);
    end
    pulse(1'b1, 2'd2, 8'd0, i2, i3);
    checks++;
    if (counter_out !== 8'd0 || i3 !== 1'b1 || irq_n !== 1'b1) begin
      errors++;
      $display("FAIL coll_sel2 got cnt=%0d irq_n=%b/%b want 0 1/1",
               counter_out, i3, irq_n);
    end
  endtask

  task automatic test_async_reset;
    logic i2, i3;
    wr(2'd0, 8'd2);
    wr(2'd1, 8'd0);
    wr(2'd3, 8'd0);
    repeat (3) pulse(1'b0, 2'd0, 8'd0, i2, i3);
    wr(2'd1, 8'd0);
    pulse(1'b0, 2'd0, 8'd0, i2, i3);
    checks++;
    if (counter_out !== 8'd2 || irq_n !== 1'b0) begin
      errors++;
      $display("FAIL arst_setup got cnt=%0d irq_n=%b want 2 0",
               counter_out, irq_n);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (irq_n !== 1'b1) begin
      errors++;
      $display("FAIL arst_irq_n got %b want 1", irq_n);
    end
    checks++;
    if (counter_out !== 8'd0) begin
      errors++;
      $display("FAIL arst_counter got %0d want 0", counter_out);
    end
    @(negedge m2);
    rst_n = 1'b1;
    @(negedge m2);
  endtask

  initial begin
    @(negedge m2);
    test_reset_count();
    test_ack_reload();
    test_low_filter();
    test_latch_zero();
    test_collision();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
